// File: rtl/video_timing_gen.sv
// Raster timing generator: hsync/vsync/de, pixel coordinates, frame-start strobe, optional colour bars (VIDEO_TIMING_COLORBAR_EN).
// Latency: every output is registered one pix_clk cycle after the h/v counter state it reflects.
// Backpressure: en=0 freezes counters and outputs (frame_start forced low); en=1 advances one pixel per cycle.
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input  logic        pix_clk,
    input  logic        resetn,
    input  logic        en,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start,
    output logic [23:0] rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        HS_ON    = 1'(HS_POL);
    localparam logic        VS_ON    = 1'(VS_POL);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        frame_start_q, frame_start_d;
    logic        de_nxt;

    // Raster counters: h wraps at end of line and carries into v; both wrap together at end of frame.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
            end
        end
    end

    // Decode the current counter state into next outputs; hold everything except the strobe when disabled.
    // vs follows v_cnt, which only moves on the h wrap, so it is inherently line-aligned.
    always_comb begin
        de_nxt        = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        de_d          = de_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_start_d = 1'b0;
        if (en) begin
            de_d          = de_nxt;
            hs_d          = (h_cnt_q >= HS_START && h_cnt_q < HS_END) ? HS_ON : ~HS_ON;
            vs_d          = (v_cnt_q >= VS_START && v_cnt_q < VS_END) ? VS_ON : ~VS_ON;
            x_d           = h_cnt_q;
            y_d           = v_cnt_q;
            frame_start_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        end
    end

    // Counter and timing output registers.
    always_ff @(posedge pix_clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            de_q          <= 1'b0;
            hs_q          <= ~HS_ON;
            vs_q          <= ~VS_ON;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            de_q          <= de_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign de          = de_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;

`ifdef VIDEO_TIMING_COLORBAR_EN
    localparam int          BAR_W    = H_ACTIVE / 8;
    localparam logic [11:0] BAR_LAST = (BAR_W > 0) ? 12'(BAR_W - 1) : 12'd0;

    logic [11:0] bar_cnt_q, bar_cnt_d;
    logic [3:0]  bar_idx_q, bar_idx_d;
    logic [23:0] rgb_q, rgb_d;
    logic [23:0] bar_colour;

    // Bar palette; indices past the eighth bar (non-multiple-of-8 widths) show black.
    always_comb begin
        case (bar_idx_q)
            4'd0:    bar_colour = 24'hFFFFFF;
            4'd1:    bar_colour = 24'hFFFF00;
            4'd2:    bar_colour = 24'h00FFFF;
            4'd3:    bar_colour = 24'h00FF00;
            4'd4:    bar_colour = 24'hFF00FF;
            4'd5:    bar_colour = 24'hFF0000;
            4'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    end

    // Bar tracker mirrors h_cnt: width counter plus bar index, both cleared when the line wraps.
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        rgb_d     = rgb_q;
        if (en) begin
            if (h_cnt_q == H_LAST) begin
                bar_cnt_d = '0;
                bar_idx_d = '0;
            end else if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_d = '0;
                bar_idx_d = (bar_idx_q == 4'd8) ? bar_idx_q : bar_idx_q + 4'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + 12'd1;
            end
            rgb_d = de_nxt ? bar_colour : 24'h000000;
        end
    end

    // Colour-bar registers, aligned with de.
    always_ff @(posedge pix_clk or negedge resetn) begin
        if (!resetn) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            rgb_q     <= '0;
        end else begin
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            rgb_q     <= rgb_d;
        end
    end

    assign rgb = rgb_q;
`else
    assign rgb = 24'h000000;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default-size instance for line timing, hold and colour bars,
// small-size instance for full-frame timing, randomized enable and mid-frame reset.
// Expected outputs come from a pixel-index model: k enabled edges since reset -> position k-1.
module tb_video_timing_gen;

`ifdef VIDEO_TIMING_COLORBAR_EN
    localparam bit BARS = 1'b1;
`else
    localparam bit BARS = 1'b0;
`endif

    logic        pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    logic        d_rstn, d_en, d_hs, d_vs, d_de, d_fs;
    logic [11:0] d_x, d_y;
    logic [23:0] d_rgb;
    logic        s_rstn, s_en, s_hs, s_vs, s_de, s_fs;
    logic [11:0] s_x, s_y;
    logic [23:0] s_rgb;

    video_timing_gen dut (
        .pix_clk(pix_clk), .resetn(d_rstn), .en(d_en),
        .hs(d_hs), .vs(d_vs), .de(d_de), .x(d_x), .y(d_y),
        .frame_start(d_fs), .rgb(d_rgb)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1)
    ) dut_s (
        .pix_clk(pix_clk), .resetn(s_rstn), .en(s_en),
        .hs(s_hs), .vs(s_vs), .de(s_de), .x(s_x), .y(s_y),
        .frame_start(s_fs), .rgb(s_rgb)
    );

    int errors = 0;
    int checks = 0;
    int dk = 0, sk = 0;
    bit dlst = 0, slst = 0;
    logic [51:0] obs, exp_v;

    // Expected {de,hs,vs,fs,x,y,rgb} after k enabled edges (lst: last edge was enabled).
    function automatic logic [51:0] ref_out(input int ha, hfp, hsw, hbp, va, vfp, vsw, vbp,
                                            input int k, input bit lst);
        int ht, vt, p, h, v;
        logic de_e, hs_e, vs_e, fs_e;
        logic [23:0] c;
        if (k == 0) return 52'd0;
        ht   = ha + hfp + hsw + hbp;
        vt   = va + vfp + vsw + vbp;
        p    = k - 1;
        h    = p % ht;
        v    = (p / ht) % vt;
        de_e = (h < ha) && (v < va);
        hs_e = (h >= ha + hfp) && (h < ha + hfp + hsw);
        vs_e = (v >= va + vfp) && (v < va + vfp + vsw);
        fs_e = lst && (h == 0) && (v == 0);
        c    = 24'h0;
        if (BARS && de_e) begin
            case (h / (ha / 8))
                0: c = 24'hFFFFFF;
                1: c = 24'hFFFF00;
                2: c = 24'h00FFFF;
                3: c = 24'h00FF00;
                4: c = 24'hFF00FF;
                5: c = 24'hFF0000;
                6: c = 24'h0000FF;
                default: c = 24'h000000;
            endcase
        end
        return {de_e, hs_e, vs_e, fs_e, 12'(h), 12'(v), c};
    endfunction

    function automatic logic [51:0] d_ref();
        return ref_out(1280, 110, 40, 220, 720, 5, 5, 20, dk, dlst);
    endfunction

    function automatic logic [51:0] s_ref();
        return ref_out(8, 2, 2, 2, 4, 1, 1, 1, sk, slst);
    endfunction

    // One clock for the default instance: drive at negedge, model at posedge, return at next negedge.
    task automatic d_tick(input bit e);
        d_en = e;
        @(posedge pix_clk);
        if (!d_rstn) begin dk = 0; dlst = 0; end
        else if (e) begin dk++; dlst = 1; end
        else dlst = 0;
        @(negedge pix_clk);
    endtask

    task automatic s_tick(input bit e);
        s_en = e;
        @(posedge pix_clk);
        if (!s_rstn) begin sk = 0; slst = 0; end
        else if (e) begin sk++; slst = 1; end
        else slst = 0;
        @(negedge pix_clk);
    endtask

    task automatic test_reset;
        d_rstn = 0; d_en = 1;
        for (int i = 0; i < 10; i++) begin
            d_tick(1);
            obs = {d_de, d_hs, d_vs, d_fs, d_x, d_y, d_rgb};
            checks++;
            if (obs !== 52'd0) begin
                errors++;
                $display("FAIL reset_values cyc%0d: got %h want 0", i, obs);
            end
        end
        d_rstn = 1;
        d_tick(1);
        checks++;
        if ({d_de, d_fs} !== 2'b11) begin
            errors++;
            $display("FAIL first_edge de/fs: got %b want 11", {d_de, d_fs});
        end
    endtask

    task automatic test_horizontal;
        int de_fall = -1, de_rise2 = -1, hs_rise = -1, hs_fall = -1;
        logic pde, phs;
        pde = d_de; phs = d_hs;
        for (int t = 1; t <= 3400; t++) begin
            d_tick(1);
            obs = {d_de, d_hs, d_vs, d_fs, d_x, d_y, d_rgb};
            exp_v = d_ref();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL horiz_model t=%0d: got %h want %h", t, obs, exp_v);
            end
            if (pde && !d_de && de_fall < 0) de_fall = t;
            if (!pde && d_de && de_rise2 < 0) de_rise2 = t;
            if (!phs && d_hs && hs_rise < 0) hs_rise = t;
            if (phs && !d_hs && hs_fall < 0) hs_fall = t;
            pde = d_de; phs = d_hs;
        end
        checks++;
        if (de_fall !== 1280) begin errors++; $display("FAIL de_high_len: got %0d want 1280", de_fall); end
        checks++;
        if (de_rise2 - de_fall !== 370) begin errors++; $display("FAIL de_low_len: got %0d want 370", de_rise2 - de_fall); end
        checks++;
        if (hs_rise !== 1390) begin errors++; $display("FAIL hs_rise_offset: got %0d want 1390", hs_rise); end
        checks++;
        if (hs_fall - hs_rise !== 40) begin errors++; $display("FAIL hs_width: got %0d want 40", hs_fall - hs_rise); end
        checks++;
        if (de_rise2 !== 1650) begin errors++; $display("FAIL line_period: got %0d want 1650", de_rise2); end
    endtask

    task automatic test_hold;
        int n = 0;
        while (d_x != 12'd500 && n < 2000) begin d_tick(1); n++; end
        checks++;
        if (d_x !== 12'd500) begin errors++; $display("FAIL hold_reach_x500: got %0d want 500", d_x); end
        for (int i = 0; i < 7; i++) begin
            d_tick(0);
            checks++;
            if ({d_x, d_fs} !== {12'd500, 1'b0}) begin
                errors++;
                $display("FAIL hold_freeze: got x=%0d fs=%b want x=500 fs=0", d_x, d_fs);
            end
            obs = {d_de, d_hs, d_vs, d_fs, d_x, d_y, d_rgb};
            exp_v = d_ref();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL hold_model: got %h want %h", obs, exp_v); end
        end
        d_tick(1);
        checks++;
        if (d_x !== 12'd501) begin errors++; $display("FAIL hold_resume: got %0d want 501", d_x); end
    endtask

    task automatic test_colorbars;
        d_rstn = 0;
        d_tick(1);
        d_rstn = 1;
        for (int t = 0; t < 1650; t++) begin
            d_tick(1);
            obs = {d_de, d_hs, d_vs, d_fs, d_x, d_y, d_rgb};
            exp_v = d_ref();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL bars_model t=%0d: got %h want %h", t, obs, exp_v); end
            if (t == 0 || t == 160 || t == 1279 || t == 1300) begin
                exp_v[23:0] = !BARS ? 24'h0 : (t == 0) ? 24'hFFFFFF : (t == 160) ? 24'hFFFF00 : 24'h000000;
                checks++;
                if (d_rgb !== exp_v[23:0]) begin
                    errors++;
                    $display("FAIL bar_colour x=%0d: got %h want %h", t, d_rgb, exp_v[23:0]);
                end
            end
        end
    endtask

    task automatic test_vertical_small;
        int fs_t0 = -1, fs_t1 = -1, vs_cnt = 0;
        bit vs_rise_ok = 1;
        logic pvs;
        s_rstn = 0;
        s_tick(1);
        s_rstn = 1;
        pvs = s_vs;
        for (int t = 0; t < 200; t++) begin
            s_tick(1);
            obs = {s_de, s_hs, s_vs, s_fs, s_x, s_y, s_rgb};
            exp_v = s_ref();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL vert_model t=%0d: got %h want %h", t, obs, exp_v); end
            if (s_fs) begin if (fs_t0 < 0) fs_t0 = t; else if (fs_t1 < 0) fs_t1 = t; end
            if (t < 98 && s_vs) vs_cnt++;
            if (!pvs && s_vs && !(s_x == 0 && s_y == 5)) vs_rise_ok = 0;
            pvs = s_vs;
        end
        checks++;
        if (fs_t1 - fs_t0 !== 98 || fs_t0 !== 0) begin
            errors++;
            $display("FAIL frame_period: got t0=%0d t1=%0d want 0 98", fs_t0, fs_t1);
        end
        checks++;
        if (vs_cnt !== 14) begin errors++; $display("FAIL vs_width: got %0d want 14", vs_cnt); end
        checks++;
        if (!vs_rise_ok) begin errors++; $display("FAIL vs_rise_pos: got misaligned want x=0 y=5"); end
    endtask

    task automatic test_random_small;
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 299) == 0) s_rstn = 0;
            else if (!s_rstn && $urandom_range(0, 1) == 0) s_rstn = 1;
            s_tick($urandom_range(0, 3) != 0);
            obs = {s_de, s_hs, s_vs, s_fs, s_x, s_y, s_rgb};
            exp_v = s_ref();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL random_model t=%0d: got %h want %h", t, obs, exp_v); end
        end
        s_rstn = 1;
    endtask

    task automatic test_midframe_reset;
        int n = 0, per = -1;
        while (s_y != 12'd3 && n < 200) begin s_tick(1); n++; end
        checks++;
        if (s_y !== 12'd3) begin errors++; $display("FAIL mid_reach_line3: got %0d want 3", s_y); end
        s_rstn = 0;
        #1;
        obs = {s_de, s_hs, s_vs, s_fs, s_x, s_y, s_rgb};
        checks++;
        if (obs !== 52'd0) begin errors++; $display("FAIL async_reset: got %h want 0", obs); end
        for (int i = 0; i < 3; i++) s_tick(1);
        s_rstn = 1;
        s_tick(1);
        checks++;
        if ({s_fs, s_de, s_x, s_y} !== {1'b1, 1'b1, 24'd0}) begin
            errors++;
            $display("FAIL restart_frame: got fs=%b de=%b x=%0d y=%0d want 1 1 0 0", s_fs, s_de, s_x, s_y);
        end
        for (int t = 1; t <= 200 && per < 0; t++) begin
            s_tick(1);
            obs = {s_de, s_hs, s_vs, s_fs, s_x, s_y, s_rgb};
            exp_v = s_ref();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL restart_model t=%0d: got %h want %h", t, obs, exp_v); end
            if (s_fs) per = t;
        end
        checks++;
        if (per !== 98) begin errors++; $display("FAIL restart_period: got %0d want 98", per); end
    endtask

    initial begin
        d_rstn = 0; d_en = 0; s_rstn = 0; s_en = 0;
        @(negedge pix_clk);
        test_reset;
        test_horizontal;
        test_hold;
        test_colorbars;
        test_vertical_small;
        test_random_small;
        test_midframe_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
